// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps all 8 input vectors of a 3-input gate and checks its responses against a truth table
module gate_sweep_checker #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [7:0] i_expected,
  input  logic       i_answer,
  output logic       o_in_a,
  output logic       o_in_b,
  output logic       o_in_c,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_fail_mask,
  output logic [3:0] o_mismatch_count
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  state_t     r_state;
  logic [2:0] r_vec;
  logic [7:0] r_hold;
  logic [7:0] r_fail_mask;
  logic [3:0] r_mcnt;
  logic       r_pass;
  logic       w_drive;
  // Sweep sequencer: hold each vector, sample answer on the last hold cycle, then report
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_vec       <= 3'd0;
      r_hold      <= 8'd0;
      r_fail_mask <= 8'h00;
      r_mcnt      <= 4'd0;
      r_pass      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start && !i_abort) begin
          r_state     <= DRIVE;
          r_vec       <= 3'd0;
          r_hold      <= 8'd0;
          r_fail_mask <= 8'h00;
          r_mcnt      <= 4'd0;
          r_pass      <= 1'b0;
        end
        DRIVE: if (i_abort) begin
          r_state <= IDLE;
          r_vec   <= 3'd0;
          r_hold  <= 8'd0;
          r_pass  <= 1'b0;
        end else if (r_hold == HOLD_LAST) begin
          if (i_answer != i_expected[r_vec]) begin
            r_fail_mask[r_vec] <= 1'b1;
            r_mcnt             <= r_mcnt + 4'd1;
          end
          r_hold <= 8'd0;
          if (r_vec == 3'd7) r_state <= DONE;
          else r_vec <= r_vec + 3'd1;
        end else begin
          r_hold <= r_hold + 8'd1;
        end
        DONE: begin
          r_state <= IDLE;
          r_vec   <= 3'd0;
          r_pass  <= (r_mcnt == 4'd0);
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign w_drive          = (r_state == DRIVE);
  assign o_in_a           = w_drive & r_vec[2];
  assign o_in_b           = w_drive & r_vec[1];
  assign o_in_c           = w_drive & r_vec[0];
  assign o_busy           = w_drive;
  assign o_done           = (r_state == DONE);
  assign o_pass           = r_pass;
  assign o_fail_mask      = r_fail_mask;
  assign o_mismatch_count = r_mcnt;
endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb_gate_sweep_checker: scoreboard bench for gate_sweep_checker at HOLD_CYCLES=20 and HOLD_CYCLES=1
module tb_gate_sweep_checker;
  typedef struct {
    logic       pass;
    logic [7:0] mask;
    logic [3:0] cnt;
    int         at;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, stuck = 1'b0;
  logic [7:0] expected = 8'h80;
  logic in_a, in_b, in_c, busy, done, pass, answer;
  logic [7:0] fail_mask;
  logic [3:0] mcnt;
  logic start1 = 1'b0;
  logic in_a1, in_b1, in_c1, busy1, done1, pass1, answer1;
  logic [7:0] fail_mask1;
  logic [3:0] mcnt1;
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  exp_t q[$];
  exp_t q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign answer  = stuck ? 1'b0 : (in_a & in_b & in_c);
  assign answer1 = in_a1 & in_b1 & in_c1;
  gate_sweep_checker #(.HOLD_CYCLES(20)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
    .i_expected(expected), .i_answer(answer),
    .o_in_a(in_a), .o_in_b(in_b), .o_in_c(in_c), .o_busy(busy), .o_done(done),
    .o_pass(pass), .o_fail_mask(fail_mask), .o_mismatch_count(mcnt));
  gate_sweep_checker #(.HOLD_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_start(start1), .i_abort(1'b0),
    .i_expected(8'h80), .i_answer(answer1),
    .o_in_a(in_a1), .o_in_b(in_b1), .o_in_c(in_c1), .o_busy(busy1), .o_done(done1),
    .o_pass(pass1), .o_fail_mask(fail_mask1), .o_mismatch_count(mcnt1));
  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic chk_quiet(input string name, input logic [7:0] m, input logic [3:0] n);
    chk({name, " busy"}, int'(busy), 0);
    chk({name, " done"}, int'(done), 0);
    chk({name, " abc"}, int'({in_a, in_b, in_c}), 0);
    chk({name, " pass"}, int'(pass), 0);
    chk({name, " mask"}, int'(fail_mask), int'(m));
    chk({name, " cnt"}, int'(mcnt), int'(n));
  endtask
  task automatic sweep(input logic [7:0] e, input logic s0, output int s);
    @(negedge clk);
    expected = e;
    stuck = s0;
    start = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    start = 1'b0;
  endtask
  // Monitor for the HOLD_CYCLES=20 instance: pops the scoreboard on every done pulse
  always begin
    @(negedge clk);
    if (done) begin
      if (q.size() == 0) chk("unexpected done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done cycle", cyc, e.at);
        chk("fail_mask", int'(fail_mask), int'(e.mask));
        chk("mismatch_count", int'(mcnt), int'(e.cnt));
        @(negedge clk);
        chk("pass", int'(pass), int'(e.pass));
      end
    end
  end
  // Monitor for the HOLD_CYCLES=1 instance
  always begin
    @(negedge clk);
    if (done1) begin
      if (q1.size() == 0) chk("unexpected done1", 1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("done1 cycle", cyc, e.at);
        chk("fail_mask1", int'(fail_mask1), int'(e.mask));
        chk("mismatch_count1", int'(mcnt1), int'(e.cnt));
        @(negedge clk);
        chk("pass1", int'(pass1), int'(e.pass));
      end
    end
  end
  initial begin
    int s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset", 8'h00, 4'd0);
    chk("reset busy1", int'(busy1), 0);
    reset = 1'b0;
    // correct AND gate, plus an ignored start in mid-sweep
    sweep(8'h80, 1'b0, s);
    q.push_back('{1'b1, 8'h00, 4'd0, s + 160});
    wait_to(s + 29);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(s + 45);
    chk("mid busy", int'(busy), 1);
    chk("mid vector", int'({in_a, in_b, in_c}), 2);
    wait_to(s + 159);
    chk("last vector", int'({in_a, in_b, in_c}), 7);
    wait_to(s + 164);
    chk("idle abc", int'({in_a, in_b, in_c}), 0);
    chk("pass held", int'(pass), 1);
    // stuck-at-0 gate
    sweep(8'h80, 1'b1, s);
    q.push_back('{1'b0, 8'h80, 4'd1, s + 160});
    wait_to(s + 164);
    // NOR table against an AND gate
    sweep(8'h01, 1'b0, s);
    q.push_back('{1'b0, 8'h81, 4'd2, s + 160});
    wait_to(s + 164);
    chk("mask held", int'(fail_mask), 8'h81);
    // abort during vector 2 keeps vector-0 mismatch
    sweep(8'h01, 1'b0, s);
    wait_to(s + 49);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk_quiet("abort", 8'h01, 4'd1);
    @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort beats start", int'(busy), 0);
    repeat (5) @(negedge clk);
    sweep(8'h80, 1'b0, s);
    q.push_back('{1'b1, 8'h00, 4'd0, s + 160});
    @(negedge clk);
    chk("restart busy", int'(busy), 1);
    chk("restart vector", int'({in_a, in_b, in_c}), 0);
    wait_to(s + 164);
    // reset mid-sweep
    sweep(8'h01, 1'b0, s);
    wait_to(s + 69);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_quiet("mid reset", 8'h00, 4'd0);
    wait_to(s + 200);
    // HOLD_CYCLES=1 sweep with an ignored start at edge s+3
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 s = cyc;
    start1 = 1'b0;
    q1.push_back('{1'b1, 8'h00, 4'd0, s + 8});
    for (int k = 0; k < 8; k++) begin
      wait_to(s + k);
      chk("h1 vector", int'({in_a1, in_b1, in_c1}), k);
      start1 = (k == 2);
    end
    start1 = 1'b0;
    wait_to(s + 12);
    chk("scoreboard drained", q.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 Parameter HOLD_CYCLES, default 20, meaning clock cycles each input vector is held before its response is sampled; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-005 abort  input  1  terminate a sweep in progress.
REQ-006 expected  input  8  truth table of the gate under test; bit i = required answer for vector i, where i = {in_a,in_b,in_c}.
REQ-007 answer  input  1  response of the 3-input gate under test, combinational from in_a/in_b/in_c.
REQ-008 in_a, in_b, in_c  output  1 each  stimulus to the gate under test; in_a = vector bit 2, in_c = vector bit 0.
REQ-009 busy  output  1  high while a sweep is in progress (DRIVE).
REQ-010 done  output  1  one-cycle pulse on sweep completion.
REQ-011 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 fail_mask  output  8  bit i set if vector i mismatched in the current or last sweep.
REQ-013 mismatch_count  output  4  number of mismatching vectors, 0..8.

Function
REQ-014 FSM states SHALL be IDLE, DRIVE and DONE.
REQ-015 IDLE -> DRIVE on an edge sampling start=1; that edge clears vector, hold counter, fail_mask, mismatch_count and pass.
REQ-016 In DRIVE, in_a/in_b/in_c SHALL present the 3-bit vector; the hold counter increments each cycle from 0.
REQ-017 The edge where hold counter = HOLD_CYCLES-1 SHALL sample answer against expected[vector].
REQ-018 On mismatch at that edge, fail_mask[vector] SHALL be set and mismatch_count incremented.
REQ-019 At the same edge, if vector < 7 then vector increments and the hold counter returns to 0; if vector = 7 the next state is DONE.
REQ-020 Each vector SHALL be driven for exactly HOLD_CYCLES cycles; vectors SHALL be applied in order 0..7 with no gap cycles.
REQ-021 With start sampled at edge 0, the final sample SHALL occur at edge 8*HOLD_CYCLES and done SHALL be high for exactly the following cycle.
REQ-022 DONE lasts one cycle, sets pass = (mismatch_count = 0) and returns to IDLE.
REQ-023 pass, fail_mask and mismatch_count SHALL hold their values in IDLE until the next accepted start.
REQ-024 start while in DRIVE or DONE SHALL be ignored, with no restart and no corruption of the sweep.
REQ-025 abort=1 in DRIVE SHALL force IDLE at that edge, including the sampling edge; the sample is discarded; done is not pulsed; pass = 0; fail_mask and mismatch_count keep their values from before that edge.
REQ-026 If abort and start are both high in IDLE, abort wins and start is ignored.
REQ-027 abort in IDLE or DONE SHALL have no effect; the DONE -> IDLE transition and done pulse proceed.
REQ-028 in_a/in_b/in_c SHALL be 0 in IDLE and DONE.
REQ-029 busy SHALL be high exactly in DRIVE.
REQ-030 All outputs SHALL be registered or decoded from registered state only, with no combinational path from answer.

Reset
REQ-031 reset SHALL take priority over start and abort.
REQ-032 reset=1 at an edge SHALL force IDLE and set vector=0 and hold counter=0.
REQ-033 On reset, outputs SHALL be: in_a=in_b=in_c=0, busy=0, done=0, pass=0, fail_mask=8'h00, mismatch_count=0.
REQ-034 reset during DRIVE SHALL discard the sweep with no done pulse.
REQ-035 The first start accepted after reset release SHALL begin at vector 0.

Verification
REQ-036 HOLD_CYCLES=20, expected=8'h80, answer = correct 3-input AND, start at edge 0 -> done at the cycle after edge 160; pass=1, fail_mask=8'h00, mismatch_count=0.
REQ-037 expected=8'h80, answer stuck at 0 -> pass=0, fail_mask=8'h80, mismatch_count=1.
REQ-038 expected=8'h01 (3-input NOR), answer = AND gate -> fail_mask=8'h81, mismatch_count=2, pass=0.
REQ-039 HOLD_CYCLES=1 -> vectors change every cycle 0..7, done at the cycle after edge 8; a second start pulse at edge 3 is ignored.
REQ-040 abort at edge 50 (HOLD_CYCLES=20, vector 2) -> IDLE at edge 50, busy=0, no done, pass=0, outputs 0; a new start then sweeps from vector 0.
REQ-041 reset at edge 70 mid-sweep -> all outputs at reset values after edge 70; no done pulse observed.
